// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIF FFT address controller: defaults,
// state encoding and the bit-reverse helper.
package fft_pkg;

  localparam int N_DEF    = 16;
  localparam int SIZE_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMP,
    ST_DRAIN,
    ST_OUT
  } state_t;

  // Reverses the low 'width' bits of val; bits above width come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = val;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_ctrl_shift_register.sv
// Fixed-latency delay line with async clear; turns the read strobe/pointer
// into the matching butterfly write-back strobe/pointer.
module shift_register #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/fft_addr_ctrl.sv
// Sequencer for the in-place radix-2 DIF FFT RAM: sample load, SIZE butterfly
// passes with write-back alignment, and bit-reversed result readout.
module fft_addr_ctrl
  import fft_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int SIZE       = SIZE_DEF,
  parameter int PIPE_LAT   = 5,
  parameter int IN_BITREV  = 0,
  parameter int OUT_BITREV = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            load_data,
  output logic [SIZE-1:0] load_adr,
  output logic            en_rd,
  output logic [SIZE-1:0] rd_ptr,
  output logic            en_wr,
  output logic [SIZE-1:0] wr_ptr,
  output logic [SIZE-2:0] tw_idx,
  output logic [SIZE-1:0] stage,
  output logic            out_valid,
  output logic            busy,
  output logic            done
);

  // state | meaning
  // IDLE  | waiting for the first sample of a frame
  // LOAD  | writing samples into RAM, load_cnt = samples accepted so far
  // COMP  | one butterfly pass: N reads, rd_cnt = 0..N-1
  // DRAIN | PIPE_LAT cycles for outstanding write-backs to land
  // OUT   | streaming results out, out_cnt = 0..N-1

  localparam logic [SIZE-1:0] CNT_MAX    = SIZE'(N - 1);
  localparam logic [SIZE-1:0] STAGE_MAX  = SIZE'(SIZE - 1);
  localparam logic [7:0]      DRAIN_INIT = 8'(PIPE_LAT - 1);

  state_t          state, state_nxt;
  logic [SIZE-1:0] load_cnt, load_cnt_nxt;
  logic [SIZE-1:0] rd_cnt, rd_cnt_nxt;
  logic [SIZE-1:0] out_cnt, out_cnt_nxt;
  logic [SIZE-1:0] stage_nxt;
  logic [7:0]      drain_cnt, drain_cnt_nxt;

  logic            en_rd_nxt, out_valid_nxt, done_nxt;
  logic [SIZE-1:0] rd_ptr_nxt;
  logic [SIZE-2:0] tw_idx_nxt;
  logic [31:0]     stg, rdc, span, pair, low, top;
  logic [SIZE:0]   sr_in, sr_out;

  assign in_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign load_data = in_valid & in_ready;
  assign load_adr  = (IN_BITREV != 0) ? SIZE'(bitrev(32'(load_cnt), SIZE)) : load_cnt;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt     = state;
    load_cnt_nxt  = load_cnt;
    rd_cnt_nxt    = rd_cnt;
    out_cnt_nxt   = out_cnt;
    stage_nxt     = stage;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (load_data) begin
          load_cnt_nxt = load_cnt + 1'b1;
          if (load_cnt == CNT_MAX) begin
            state_nxt  = ST_COMP;
            stage_nxt  = '0;
            rd_cnt_nxt = '0;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_COMP: begin
        rd_cnt_nxt = rd_cnt + 1'b1;
        if (rd_cnt == CNT_MAX) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == 8'd0) begin
          if (stage == STAGE_MAX) begin
            state_nxt   = ST_OUT;
            out_cnt_nxt = '0;
          end else begin
            state_nxt  = ST_COMP;
            stage_nxt  = stage + 1'b1;
            rd_cnt_nxt = '0;
          end
        end else begin
          drain_cnt_nxt = drain_cnt - 8'd1;
        end
      end
      ST_OUT: begin
        out_cnt_nxt = out_cnt + 1'b1;
        if (out_cnt == CNT_MAX) begin
          state_nxt = ST_IDLE;
          stage_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-cycle state/counters so the registered
  // pointers line up with the counters in the same cycle.
  always_comb begin
    stg  = 32'(stage_nxt);
    rdc  = 32'(rd_cnt_nxt);
    span = 32'(N) >> (stg + 32'd1);
    pair = rdc >> 1;
    low  = pair & (span - 32'd1);
    top  = ((pair >> (32'(SIZE - 1) - stg)) << (32'(SIZE) - stg)) | low;

    en_rd_nxt     = (state_nxt == ST_COMP);
    out_valid_nxt = (state_nxt == ST_OUT);
    done_nxt      = (state_nxt == ST_OUT) && (out_cnt_nxt == CNT_MAX);
    rd_ptr_nxt    = '0;
    tw_idx_nxt    = '0;
    if (state_nxt == ST_COMP) begin
      rd_ptr_nxt = SIZE'(top + (rdc[0] ? span : 32'd0));
      tw_idx_nxt = (SIZE-1)'(low << stg);
    end else if (state_nxt == ST_OUT) begin
      rd_ptr_nxt = (OUT_BITREV != 0) ? SIZE'(bitrev(32'(out_cnt_nxt), SIZE)) : out_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      load_cnt  <= '0;
      rd_cnt    <= '0;
      out_cnt   <= '0;
      stage     <= '0;
      drain_cnt <= '0;
      en_rd     <= 1'b0;
      rd_ptr    <= '0;
      tw_idx    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_cnt  <= load_cnt_nxt;
      rd_cnt    <= rd_cnt_nxt;
      out_cnt   <= out_cnt_nxt;
      stage     <= stage_nxt;
      drain_cnt <= drain_cnt_nxt;
      en_rd     <= en_rd_nxt;
      rd_ptr    <= rd_ptr_nxt;
      tw_idx    <= tw_idx_nxt;
      out_valid <= out_valid_nxt;
      done      <= done_nxt;
    end
  end

  // Output-phase addresses never reach the write-back path.
  assign sr_in = {en_rd, en_rd ? rd_ptr : {SIZE{1'b0}}};

  shift_register #(
    .WIDTH(SIZE + 1),
    .DEPTH(PIPE_LAT)
  ) u_wb_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sr_in),
    .q    (sr_out)
  );

  assign en_wr  = sr_out[SIZE];
  assign wr_ptr = sr_out[SIZE-1:0];

endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Directed bench for fft_addr_ctrl (N=16, PIPE_LAT=5, bit-reversed load and output).
module tb_fft_addr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, load_data, en_rd, en_wr, out_valid, busy, done;
  logic [3:0] load_adr, rd_ptr, wr_ptr, stage;
  logic [2:0] tw_idx;

  int checks = 0;
  int failures = 0;

  int exp_rev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int exp_rd [4][16] = '{
    '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15},
    '{0, 4, 1, 5, 2, 6, 3, 7, 8, 12, 9, 13, 10, 14, 11, 15},
    '{0, 2, 1, 3, 4, 6, 5, 7, 8, 10, 9, 11, 12, 14, 13, 15},
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15}};
  int exp_tw [4][16] = '{
    '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7},
    '{0, 0, 2, 2, 4, 4, 6, 6, 0, 0, 2, 2, 4, 4, 6, 6},
    '{0, 0, 4, 4, 0, 0, 4, 4, 0, 0, 4, 4, 0, 0, 4, 4},
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

  fft_addr_ctrl #(
    .N(16), .SIZE(4), .PIPE_LAT(5), .IN_BITREV(1), .OUT_BITREV(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .load_data(load_data),
    .load_adr (load_adr),
    .en_rd    (en_rd),
    .rd_ptr   (rd_ptr),
    .en_wr    (en_wr),
    .wr_ptr   (wr_ptr),
    .tw_idx   (tw_idx),
    .stage    (stage),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " en_rd"}, en_rd, 0);
    chk({tag, " rd_ptr"}, rd_ptr, 0);
    chk({tag, " en_wr"}, en_wr, 0);
    chk({tag, " wr_ptr"}, wr_ptr, 0);
    chk({tag, " tw_idx"}, tw_idx, 0);
    chk({tag, " stage"}, stage, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " in_ready"}, in_ready, 1);
    chk({tag, " load_adr"}, load_adr, 0);
  endtask

  // Entered and left at posedge+1. abort_s/abort_k stop the frame just before
  // checking that COMP cycle (abort_s < 0 runs the frame to completion).
  task automatic run_frame(input bit gaps, input bit hold_valid, input int abort_s, input int abort_k);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        #1;
        chk("gap load_data", load_data, 0);
        next_cycle();
      end
      in_valid = 1'b1;
      #1;
      chk("load_data", load_data, 1);
      chk("load_adr", load_adr, exp_rev[i]);
      next_cycle();
      if (i == 0) chk("busy after first load", busy, 1);
    end
    if (!hold_valid) in_valid = 1'b0;

    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 16; k++) begin
        if (s == abort_s && k == abort_k) return;
        #1;
        chk("comp en_rd", en_rd, 1);
        chk("comp rd_ptr", rd_ptr, exp_rd[s][k]);
        chk("comp tw_idx", tw_idx, exp_tw[s][k]);
        chk("comp stage", stage, s);
        chk("comp load_data", load_data, 0);
        chk("comp in_ready", in_ready, 0);
        if (k >= 5) begin
          chk("comp en_wr", en_wr, 1);
          chk("comp wr_ptr", wr_ptr, exp_rd[s][k-5]);
        end else begin
          chk("comp en_wr early", en_wr, 0);
        end
        next_cycle();
      end
      for (int d = 0; d < 5; d++) begin
        #1;
        chk("drain en_rd", en_rd, 0);
        chk("drain en_wr", en_wr, 1);
        chk("drain wr_ptr", wr_ptr, exp_rd[s][11+d]);
        chk("drain busy", busy, 1);
        next_cycle();
      end
    end

    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("out out_valid", out_valid, 1);
      chk("out rd_ptr", rd_ptr, exp_rev[k]);
      chk("out done", done, (k == 15) ? 1 : 0);
      chk("out en_rd", en_rd, 0);
      chk("out en_wr", en_wr, 0);
      next_cycle();
    end
    #1;
    check_idle_outputs("after frame");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    check_idle_outputs("post reset");

    run_frame(1'b0, 1'b0, -1, 0);
    run_frame(1'b1, 1'b1, -1, 0);

    run_frame(1'b0, 1'b0, 1, 6);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid-comp reset");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("no en_wr after reset", en_wr, 0);
      chk("idle after reset", busy, 0);
      next_cycle();
    end

    run_frame(1'b0, 1'b0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
